// File: rtl/modmul_mmio.sv
// Memory-mapped modular multiplier: R = (A*B) mod N by interleaved shift-add,
// one bit of A per cycle, MSB first. Register window sits on the MEM-stage bus.
module modmul_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int          OPW       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done_irq
);

  localparam int CW = (OPW > 1) ? $clog2(OPW) : 1;
  // Two guard bits: 2*acc + B stays below 3*N when A, B < N.
  localparam int AW = OPW + 2;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_n;
  logic [OPW-1:0]   a, b, n, result;
  logic [AW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic             done, err;

  logic [2:0]       ofs;
  logic             wr, start, clr, n_zero;
  logic [AW-1:0]    n_ext, t0, t1, t2;
  logic             unused;

  assign sel    = (addr[31:5] == BASE_ADDR[31:5]);
  assign ofs    = addr[4:2];
  assign wr     = we & sel;
  assign start  = wr && (ofs == 3'd3) && wdata[0];
  assign clr    = wr && (ofs == 3'd3) && wdata[1];
  assign n_zero = (n == '0);
  assign busy   = (state == RUN);
  assign done_irq = (state == FIN);
  assign unused = ^{addr[1:0], acc[AW-1]};

  // One shift-add step with up to two conditional subtractions of N.
  always_comb begin
    n_ext = {2'b00, n};
    t0    = {acc[AW-2:0], 1'b0} + (a[cnt] ? {2'b00, b} : '0);
    t1    = (t0 >= n_ext) ? (t0 - n_ext) : t0;
    t2    = (t1 >= n_ext) ? (t1 - n_ext) : t1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next state: N==0 skips the run and goes straight to FIN with err set.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = n_zero ? FIN : RUN;
      RUN:     if (cnt == '0) state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand registers, accumulator, status flags. Later assignments win,
  // so start overrides clear and FIN's done overrides clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a <= '0; b <= '0; n <= '0; result <= '0;
      acc <= '0; cnt <= '0; done <= 1'b0; err <= 1'b0;
    end else begin
      if (state == IDLE && wr) begin
        case (ofs)
          3'd0:    a <= wdata[OPW-1:0];
          3'd1:    b <= wdata[OPW-1:0];
          3'd2:    n <= wdata[OPW-1:0];
          default: ;
        endcase
      end
      if (clr) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      case (state)
        IDLE: if (start) begin
          done <= 1'b0;
          err  <= n_zero;
          acc  <= '0;
          cnt  <= CW'(OPW - 1);
          if (n_zero) result <= '0;
        end
        RUN: begin
          acc <= t2;
          cnt <= cnt - 1'b1;
          if (cnt == '0) result <= t2[OPW-1:0];
        end
        FIN: done <= 1'b1;
        default: ;
      endcase
    end
  end

  // Register read mux, combinational from addr.
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (ofs)
        3'd0:    rdata = 32'(a);
        3'd1:    rdata = 32'(b);
        3'd2:    rdata = 32'(n);
        3'd3:    rdata = {29'b0, err, done, busy};
        3'd4:    rdata = 32'(result);
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_modmul_mmio.sv
// Directed bench for modmul_mmio: hand-computed vectors, cycle counts, window decode.
module tb_modmul_mmio;

  localparam logic [31:0] BA   = 32'h0000_0400;
  localparam logic [31:0] RA   = BA + 32'h00;
  localparam logic [31:0] RB   = BA + 32'h04;
  localparam logic [31:0] RN   = BA + 32'h08;
  localparam logic [31:0] RC   = BA + 32'h0C;
  localparam logic [31:0] RR   = BA + 32'h10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        we, sel, busy, done_irq;

  int nvec = 0;
  int nbad = 0;

  modmul_mmio #(.BASE_ADDR(BA), .OPW(32)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
    .sel(sel), .rdata(rdata), .busy(busy), .done_irq(done_irq)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick;
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; we = 1'b0;
    #1;
    d = rdata;
  endtask

  task automatic run_cnt(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick;
    end
  endtask

  logic [31:0] d;
  int n;

  initial begin
    reset = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    tick; tick;
    reset = 1'b1;
    // reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq", 32'(done_irq), 32'd0);
    rd(RA, d); chk("rst_a", d, 32'd0);
    rd(RN, d); chk("rst_n", d, 32'd0);
    rd(RR, d); chk("rst_res", d, 32'd0);
    rd(RC, d); chk("rst_stat", d, 32'd0);
    tick;

    // 7*5 mod 11 = 2
    wr(RA, 7); wr(RB, 5); wr(RN, 11); wr(RC, 1);
    chk("r1_busy", 32'(busy), 32'd1);
    run_cnt(n);
    chk("r1_cycles", 32'(n), 32'd32);
    chk("r1_irq", 32'(done_irq), 32'd1);
    rd(RR, d); chk("r1_res", d, 32'd2);
    rd(RC, d); chk("r1_stat_fin", d, 32'd0);
    tick;
    chk("r1_irq_off", 32'(done_irq), 32'd0);
    rd(RC, d); chk("r1_stat", d, 32'h2);

    // clear done, RESULT holds
    wr(RC, 2);
    rd(RC, d); chk("clr_stat", d, 32'd0);
    rd(RR, d); chk("clr_res", d, 32'd2);
    tick;

    // window decode
    wr(BA + 32'h20, 32'h55);
    chk("win_hi_sel", 32'(sel), 32'd0);
    wr(BA - 32'h4, 32'h66);
    chk("win_lo_sel", 32'(sel), 32'd0);
    rd(RA, d); chk("win_a", d, 32'd7);
    rd(RB, d); chk("win_b", d, 32'd5);
    tick;
    wr(BA + 32'h14, 32'hFFFF_FFFF);
    rd(BA + 32'h14, d); chk("win_14", d, 32'd0);
    chk("win_14_sel", 32'(sel), 32'd1);
    tick;

    // (N-1)^2 mod N = 1, exercises the guard bits
    wr(RA, 32'hFFFF_FFFA); wr(RB, 32'hFFFF_FFFA); wr(RN, 32'hFFFF_FFFB); wr(RC, 1);
    run_cnt(n);
    chk("big_cycles", 32'(n), 32'd32);
    rd(RR, d); chk("big_res", d, 32'd1);
    rd(RN, d); chk("big_n", d, 32'hFFFF_FFFB);
    tick;

    // N == 0: straight to FIN with err
    wr(RN, 0); wr(RC, 1);
    chk("n0_busy", 32'(busy), 32'd0);
    chk("n0_irq", 32'(done_irq), 32'd1);
    tick;
    chk("n0_irq_off", 32'(done_irq), 32'd0);
    rd(RC, d); chk("n0_stat", d, 32'h6);
    rd(RR, d); chk("n0_res", d, 32'd0);
    tick;

    // mid-run writes ignored
    wr(RA, 7); wr(RB, 5); wr(RN, 11); wr(RC, 1);
    for (int i = 0; i < 5; i++) tick;
    wr(RA, 3); wr(RC, 1);
    run_cnt(n);
    chk("mid_cycles", 32'(n + 7), 32'd32);
    rd(RR, d); chk("mid_res", d, 32'd2);
    rd(RA, d); chk("mid_a", d, 32'd7);
    tick;

    // reset in the middle of a run
    wr(RC, 1);
    for (int i = 0; i < 9; i++) tick;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    chk("mrst_busy", 32'(busy), 32'd0);
    rd(RR, d); chk("mrst_res", d, 32'd0);
    rd(RC, d); chk("mrst_stat", d, 32'd0);
    tick;
    // 9*10 mod 13 = 12
    wr(RA, 9); wr(RB, 10); wr(RN, 13); wr(RC, 1);
    run_cnt(n);
    chk("post_cycles", 32'(n), 32'd32);
    rd(RR, d); chk("post_res", d, 32'd12);
    tick;
    rd(RC, d); chk("post_stat", d, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
